// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: FSM encodings, default timing and frame geometry.
package ps2_host_tx_pkg;

  localparam int unsigned DEF_INHIBIT_CYCLES = 5000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;
  localparam int unsigned PS2_FRAME_BITS     = 11;
  localparam int unsigned PS2_DATA_BITS      = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_state_e;

  typedef struct packed {
    logic                     parity;
    logic [PS2_DATA_BITS-1:0] data;
  } ps2_tx_payload_t;

  // Odd parity: parity bit makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Three-flop synchronizer for one open-drain PS/2 line with falling-edge detect.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic fall_c_o
);

  logic [2:0] sync_q;

  // Two metastability stages plus one history stage, preset to the idle-high bus level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], line_i};
    end
  end

  assign level_o  = sync_q[1];
  assign fall_c_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift out byte+parity, check ACK.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned BIT_W = $clog2(PS2_FRAME_BITS + 1);

  logic clk_sync, clk_fall;
  logic data_sync, data_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk      (clk),
    .rst_n    (clrn),
    .line_i   (ps2_clk_in),
    .level_o  (clk_sync),
    .fall_c_o (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk      (clk),
    .rst_n    (clrn),
    .line_i   (ps2_data_in),
    .level_o  (data_sync),
    .fall_c_o (data_fall_unused)
  );

  ps2_state_e      state_q, state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  ps2_tx_payload_t  frame_q, frame_d;
  logic clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic busy_q, busy_d, done_q, done_d, ack_err_q, ack_err_d, timeout_q, timeout_d;
  logic wd_live;

  // Next-state and next-output decode; watchdog applies to every device-clocked state
  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    wd_d      = '0;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    timeout_d = 1'b0;
    wd_live   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          frame_d.data   = tx_byte;
          frame_d.parity = odd_parity(tx_byte);
          busy_d         = 1'b1;
          ack_err_d      = 1'b0;
          clk_oe_d       = 1'b1;
          data_oe_d      = (INHIBIT_CYCLES < 2);
          inh_cnt_d      = '0;
          state_d        = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        inh_cnt_d = inh_cnt_q + INH_W'(1);
        if (INHIBIT_CYCLES >= 2 && inh_cnt_q == INH_W'(INHIBIT_CYCLES - 2)) begin
          data_oe_d = 1'b1;
        end
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          clk_oe_d  = 1'b0;
          bit_cnt_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        wd_live = 1'b1;
        if (clk_fall) begin
          bit_cnt_d = BIT_W'(1);
          data_oe_d = ~frame_q.data[0];
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        wd_live = 1'b1;
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q < BIT_W'(PS2_DATA_BITS)) begin
            data_oe_d = ~frame_q.data[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == BIT_W'(PS2_DATA_BITS)) begin
            data_oe_d = ~frame_q.parity;
          end else begin
            // Stop bit: release data so the device can drive the ACK
            data_oe_d = 1'b0;
            state_d   = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        wd_live = 1'b1;
        if (clk_fall) begin
          bit_cnt_d = BIT_W'(PS2_FRAME_BITS);
          ack_err_d = data_sync;
          state_d   = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        wd_live = 1'b1;
        if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wd_live) begin
      wd_d = clk_fall ? '0 : wd_q + WD_W'(1);
      if (!clk_fall && !done_d && wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        timeout_d = 1'b1;
        state_d   = ST_IDLE;
      end
    end
  end

  // State and registered outputs; reset releases both bus lines immediately
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= ST_IDLE;
      inh_cnt_q <= '0;
      wd_q      <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      wd_q      <= wd_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a scripted PS/2 device and a cycle-level reference.
module tb_ps2_host_tx;

  localparam int INH  = 10;
  localparam int TO   = 100;
  localparam int SENT = 1000000000;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic       dev_clk, dev_data;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       busy, done, ack_err, timeout;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_start    (tx_start),
    .tx_byte     (tx_byte),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .timeout     (timeout)
  );

  // Wired-AND open-drain bus
  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  int n = 0;
  always @(posedge clk) n <= n + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, n, act, exp);
    end
  endtask

  // Reference model: frame start cycle, device falling-edge times, expected line drive per edge
  logic m_active = 1'b0;
  int   A = 0;
  int   end_n = SENT;
  logic m_kind_done = 1'b0;
  logic m_ack_exp = 1'b0;
  int   fall_n [0:11];
  logic drv [0:11];
  int   k_eff;
  logic live;

  always @(negedge clk) begin
    live = m_active && (n >= A) && (n <= end_n);
    if (!live) begin
      check("idle_busy",    32'(busy),        32'd0);
      check("idle_clk_oe",  32'(ps2_clk_oe),  32'd0);
      check("idle_data_oe", 32'(ps2_data_oe), 32'd0);
      check("idle_done",    32'(done),        32'd0);
      check("idle_timeout", 32'(timeout),     32'd0);
    end else if (n == end_n) begin
      check("end_busy",    32'(busy),        32'd0);
      check("end_clk_oe",  32'(ps2_clk_oe),  32'd0);
      check("end_data_oe", 32'(ps2_data_oe), 32'd0);
      check("end_done",    32'(done),        32'(m_kind_done));
      check("end_timeout", 32'(timeout),     32'(!m_kind_done));
      if (m_kind_done) check("end_ack_err", 32'(ack_err), 32'(m_ack_exp));
    end else begin
      k_eff = 0;
      for (int k = 1; k <= 11; k++) if (fall_n[k] + 3 <= n) k_eff = k;
      check("frm_busy",    32'(busy),       32'd1);
      check("frm_done",    32'(done),       32'd0);
      check("frm_timeout", 32'(timeout),    32'd0);
      check("frm_clk_oe",  32'(ps2_clk_oe), 32'((n - A) < INH));
      check("frm_data_oe", 32'(ps2_data_oe),
            ((n - A) < INH - 1) ? 32'd0 : 32'(drv[k_eff]));
    end
  end

  int   done_cnt = 0;
  int   to_cnt = 0;
  logic last_ack = 1'b0;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      last_ack = ack_err;
    end
    if (timeout) to_cnt++;
  end

  logic [9:0] smp;

  // One host transmission seen from the device side
  task automatic run_frame(input logic [7:0] b, input logic [9:0] exp_frame, input bit ack,
                           input int stop_at, input bit poke, input bit noclk);
    int   hi, guard, d0, t0;
    logic par;
    d0 = done_cnt;
    t0 = to_cnt;
    @(negedge clk);
    par = 1'b1;
    for (int i = 0; i < 8; i++) if (b[i]) par = ~par;
    drv[0] = 1'b1;
    for (int i = 1; i <= 8; i++) drv[i] = ~b[i-1];
    drv[9]  = ~par;
    drv[10] = 1'b0;
    drv[11] = 1'b0;
    for (int i = 0; i <= 11; i++) fall_n[i] = SENT;
    m_ack_exp   = !ack;
    m_kind_done = !noclk;
    A           = n + 1;
    end_n       = noclk ? (A + INH + TO) : SENT;
    m_active    = 1'b1;
    tx_byte     = b;
    tx_start    = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    hi = 0;
    while (ps2_clk_oe && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    check("inhibit_len", 32'(hi), 32'(INH));
    if (!noclk) begin
      repeat (5) @(negedge clk);
      smp = '0;
      for (int k = 1; k <= 11; k++) begin
        dev_clk   = 1'b0;
        fall_n[k] = n;
        if (k == stop_at) return;
        repeat (10) @(negedge clk);
        if (k <= 10) smp[k-1] = ps2_data_in;
        dev_clk = 1'b1;
        if (k == 11) begin
          dev_data = 1'b1;
          end_n    = n + 3;
        end
        if (poke && k == 3) begin
          tx_byte  = ~b;
          tx_start = 1'b1;
          @(negedge clk);
          tx_start = 1'b0;
          repeat (4) @(negedge clk);
        end else begin
          repeat (5) @(negedge clk);
        end
        if (k == 10 && ack) dev_data = 1'b0;
        repeat (5) @(negedge clk);
      end
      check("frame_bits", 32'(smp), 32'(exp_frame));
    end
    guard = 0;
    while (n <= end_n + 1 && guard < 400) begin
      guard++;
      @(negedge clk);
    end
    check("end_reached", 32'(n > end_n + 1), 32'd1);
    check("done_count", 32'(done_cnt - d0), noclk ? 32'd0 : 32'd1);
    check("timeout_count", 32'(to_cnt - t0), noclk ? 32'd1 : 32'd0);
    if (!noclk) check("ack_err_seen", 32'(last_ack), 32'(!ack));
  endtask

  initial begin
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    tx_start = 1'b0;
    tx_byte  = 8'h00;
    #1 clrn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_clk_oe",  32'(ps2_clk_oe),  32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_done",    32'(done),        32'd0);
    check("rst_ack_err", 32'(ack_err),     32'd0);
    check("rst_timeout", 32'(timeout),     32'd0);
    clrn = 1'b1;
    repeat (3) @(negedge clk);

    // {stop, parity, data} as the device samples them
    run_frame(8'hED, 10'h3ED, 1'b1, 0, 1'b0, 1'b0);
    run_frame(8'h01, 10'h201, 1'b1, 0, 1'b0, 1'b0);
    run_frame(8'hFF, 10'h3FF, 1'b1, 0, 1'b0, 1'b0);
    run_frame(8'hF4, 10'h2F4, 1'b0, 0, 1'b0, 1'b0);
    run_frame(8'hA5, 10'h3A5, 1'b1, 0, 1'b1, 1'b0);
    run_frame(8'h5A, 10'h000, 1'b1, 0, 1'b0, 1'b1);

    // Reset in the middle of a frame, just after edge 5 has been acted on
    run_frame(8'h3C, 10'h000, 1'b1, 5, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    clrn     = 1'b0;
    m_active = 1'b0;
    #1;
    check("mid_rst_clk_oe",  32'(ps2_clk_oe),  32'd0);
    check("mid_rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("mid_rst_busy",    32'(busy),        32'd0);
    check("partial_bits", 32'(smp[3:0]), 32'hC);
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    // Leftover device clocking must not restart anything
    for (int i = 0; i < 6; i++) begin
      dev_clk = 1'b1;
      repeat (10) @(negedge clk);
      dev_clk = 1'b0;
      repeat (10) @(negedge clk);
    end
    dev_clk = 1'b1;
    repeat (10) @(negedge clk);
    run_frame(8'hED, 10'h3ED, 1'b1, 0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_time_limit: got no finish, want finish before 3000000");
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter: INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before request-to-send (100 us at 50 MHz).
REQ-002 Parameter: TIMEOUT_CYCLES, 1000000, max clk cycles allowed between consecutive device clock falling edges.
REQ-003 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port: clrn  input  1  reset, asynchronous, active-low.
REQ-005 Port: ps2_clk_in  input  1  sampled level of the open-drain PS/2 clock line.
REQ-006 Port: ps2_data_in  input  1  sampled level of the open-drain PS/2 data line.
REQ-007 Port: ps2_clk_oe  output  1  1 = pull PS/2 clock low, 0 = release.
REQ-008 Port: ps2_data_oe  output  1  1 = pull PS/2 data low, 0 = release.
REQ-009 Port: tx_start  input  1  one-cycle request to send tx_byte.
REQ-010 Port: tx_byte  input  8  command byte to the device, captured when tx_start is accepted.
REQ-011 Port: busy  output  1  high from accepted tx_start until return to IDLE.
REQ-012 Port: done  output  1  one-cycle pulse on completed frame (ACK phase reached).
REQ-013 Port: ack_err  output  1  valid with done; 1 = device did not pull data low in the ACK bit.
REQ-014 Port: timeout  output  1  one-cycle pulse when a frame is aborted by the watchdog.

Function
REQ-015 ps2_clk_in and ps2_data_in SHALL pass a 3-flop synchronizer; falling edge = previous synced 1, current synced 0 (2-cycle detect latency).
REQ-016 States SHALL be IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE.
REQ-017 IDLE: tx_start=1 captures tx_byte, computes odd parity, sets busy, enters INHIBIT next cycle; tx_start in any other state is ignored.
REQ-018 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; on the last cycle ps2_data_oe goes 1, then next cycle ps2_clk_oe=0 and state START.
REQ-019 START/SHIFT: falling-edge count k increments per device falling edge; edges 1-8 drive data bit k-1 (LSB first, ps2_data_oe = ~bit); edge 9 drives parity; edge 10 releases data (stop bit); then state ACK.
REQ-020 ACK: on edge 11 sample synced data; ack_err latched = synced data (0 = ACK ok); state WAIT_IDLE.
REQ-021 WAIT_IDLE: when synced clock and data both 1, pulse done for one cycle, clear busy, return IDLE.
REQ-022 Watchdog: counter clears on every falling edge and on entry to START; in START/SHIFT/ACK/WAIT_IDLE, reaching TIMEOUT_CYCLES releases both lines, pulses timeout, clears busy, returns IDLE; done not pulsed.
REQ-023 Outputs SHALL change only on the clk rising edge; ps2_*_oe SHALL be registered (no glitches).
REQ-024 Device traffic arriving in IDLE SHALL be ignored; INHIBIT SHALL override any device frame in progress.

Reset
REQ-025 clrn=0 SHALL asynchronously force IDLE, ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, ack_err=0, timeout=0, counters 0, synchronizers to 1.
REQ-026 Reset mid-frame SHALL release both lines within the reset assertion with no partial frame resumed after clrn rises.

Structure
REQ-027 State encodings, default INHIBIT_CYCLES/TIMEOUT_CYCLES and PS/2 frame length (11) SHALL live in the shared ps2 definitions package used with the keyboard receiver.
REQ-028 One sub-module, ps2_line_sync (3-flop synchronizer plus falling-edge detect), instantiated once per line.

Verification (INHIBIT_CYCLES=10, TIMEOUT_CYCLES=100, device model clocks at 1 per 20 cycles)
REQ-029 tx_byte=8'hED -> clk_oe high 10 cycles; data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; model ACKs -> done pulse, ack_err=0, busy 0.
REQ-030 tx_byte=8'h01 -> parity bit 0; tx_byte=8'hFF -> parity 1; both complete with ack_err=0.
REQ-031 Model leaves data high on edge 11 -> done pulse with ack_err=1.
REQ-032 Model never clocks after START -> timeout pulse 100 cycles after START entry, both oe 0, done never pulses.
REQ-033 tx_start pulsed during SHIFT -> ignored, frame bits unchanged; clrn low at edge 5 -> both oe 0 immediately, IDLE after release.
